regfile_dump: RTL

Sequential readout engine for the 32 x 32-bit register file. On a start pulse it sweeps a programmable address range through the register file's read port. It emits each register as two 16-bit halfwords on a valid/ready stream, low half first. It is the read-side counterpart of the switch/button write path: it feeds LED/UART display logic so the whole file can be inspected without manual address loading.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_dump.sv | 122 ++++++++++++
 2 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and state encoding for the register file dump engine
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int OUT_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_SEND_LO = 3'd2,
    ST_SEND_HI = 3'd3,
    ST_FINISH  = 3'd4
  } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - sweeps a register range and streams each register as two halfwords
module regfile_dump #(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int OUT_W    = regfile_pkg::OUT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  import regfile_pkg::*;

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [ADDR_W-1:0] addr_next;
  logic              at_last;

  // Next sweep address; wraps past the top register back to x0.
  always_comb begin
    addr_next = rf_addr_q + 1'b1;
    if (rf_addr_q == ADDR_W'(NUM_REGS - 1)) begin
      addr_next = '0;
    end
  end

  assign at_last = (rf_addr_q == last_q);

  // Sweep sequencing, stream outputs and abort override.
  always_comb begin
    state_d   = state_q;
    rf_addr_d = rf_addr_q;
    last_d    = last_q;
    hold_d    = hold_q;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    done      = 1'b0;
    busy      = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          last_d    = last_reg;
          rf_addr_d = first_reg;
          state_d   = ST_READ;
        end
      end
      ST_READ: begin
        // Snapshot so later writes to the file cannot tear the halfword pair.
        hold_d  = rf_data;
        state_d = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        out_valid = 1'b1;
        out_data  = hold_q[OUT_W-1:0];
        if (out_ready) begin
          state_d = ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        out_valid = 1'b1;
        out_data  = hold_q[DATA_W-1:OUT_W];
        out_last  = at_last;
        if (out_ready) begin
          if (at_last) begin
            state_d = ST_FINISH;
          end else begin
            rf_addr_d = addr_next;
            state_d   = ST_READ;
          end
        end
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort beats a same-cycle handshake: nothing advances, sweep just ends.
    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      rf_addr_d = rf_addr_q;
      hold_d    = hold_q;
    end
  end

  // State, address, end-of-range and snapshot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rf_addr_q <= '0;
      last_q    <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      rf_addr_q <= rf_addr_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
    end
  end

  assign rf_addr = rf_addr_q;

endmodule
